// File: rtl/signature_test_sequencer.sv
// -----------------------------------------------------------------------------
// signature_test_sequencer
//
// Purpose
//   Runs the CME341 processor signature test in hardware. A run consists of
//   NUM_EPOCHS epochs of EPOCH_LEN cycles each. Every epoch:
//     - drives a fixed reset pattern into the processor (RST_SEQ),
//     - lets an 8-bit stimulus counter run (its top nibble feeds i_pins),
//     - folds the processor observation byte into a 16-bit rotate-add
//       signature accumulator,
//     - captures one signature at epoch cycle CAPTURE_AT.
//
// Parameters
//   EPOCH_LEN   cycles per epoch (must be >= CAPTURE_AT + 2)
//   CAPTURE_AT  epoch cycle index at which the accumulator is captured
//   NUM_EPOCHS  epochs per run (1..4)
//   ALT_EPOCH   first epoch index that uses seed_b instead of seed_a
//
// Ports
//   clk        in   1   system clock
//   reset      in   1   synchronous, active-high reset
//   start      in   1   one-cycle pulse; starts a run from IDLE or DONE
//   seed_a     in   8   seed for epochs below ALT_EPOCH
//   seed_b     in   8   seed for epochs at or above ALT_EPOCH
//   obs_data   in   8   XOR-reduced processor observation byte
//   dut_reset  out  1   reset driven into the processor
//   stimulus   out  8   stimulus counter ([7:4] drive processor i_pins)
//   seed       out  8   seed latched for the current epoch
//   sig_data   out  16  last captured signature
//   sig_epoch  out  2   epoch index that produced sig_data
//   sig_valid  out  1   one-cycle pulse when sig_data updates
//   busy       out  1   high in RST_SEQ or RUN
//   done       out  1   high in DONE
// -----------------------------------------------------------------------------
module signature_test_sequencer #(
  parameter int EPOCH_LEN  = 320,
  parameter int CAPTURE_AT = 310,
  parameter int NUM_EPOCHS = 3,
  parameter int ALT_EPOCH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  seed_a,
  input  logic [7:0]  seed_b,
  input  logic [7:0]  obs_data,
  output logic        dut_reset,
  output logic [7:0]  stimulus,
  output logic [7:0]  seed,
  output logic [15:0] sig_data,
  output logic [1:0]  sig_epoch,
  output logic        sig_valid,
  output logic        busy,
  output logic        done
);

  // Epoch cycle counter wide enough to hold EPOCH_LEN-1.
  localparam int ECNT_W = (EPOCH_LEN > 2) ? $clog2(EPOCH_LEN) : 2;

  localparam logic [ECNT_W-1:0] ECNT_ONE     = ECNT_W'(1);
  localparam logic [ECNT_W-1:0] ECNT_REL_LO  = ECNT_W'(6);   // first cycle with processor reset released
  localparam logic [ECNT_W-1:0] ECNT_RST_END = ECNT_W'(9);   // last RST_SEQ cycle, reset re-asserted
  localparam logic [ECNT_W-1:0] ECNT_CAP     = ECNT_W'(CAPTURE_AT);
  localparam logic [ECNT_W-1:0] ECNT_LAST    = ECNT_W'(EPOCH_LEN - 1);
  localparam logic [1:0]        EPOCH_LAST   = 2'(NUM_EPOCHS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RST_SEQ = 2'd1,
    S_RUN     = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t              state_q,     state_d;
  logic [ECNT_W-1:0]   ecnt_q,      ecnt_d;
  logic [1:0]          epoch_q,     epoch_d;
  logic [7:0]          seed_q,      seed_d;
  logic [7:0]          stim_q,      stim_d;
  logic [15:0]         acc_q,       acc_d;
  logic [15:0]         sig_data_q,  sig_data_d;
  logic [1:0]          sig_epoch_q, sig_epoch_d;
  logic                sig_valid_q, sig_valid_d;

  // Control/datapath intermediates
  logic                epoch_entry;   // entering RST_SEQ for a new epoch this cycle
  logic                dut_reset_c;   // processor reset for the current cycle
  logic                capture;
  logic [7:0]          scr;
  logic [7:0]          add;

  // ---------------------------------------------------------------------------
  // Control FSM: state, epoch cycle counter, epoch index
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    ecnt_d      = ecnt_q;
    epoch_d     = epoch_q;
    epoch_entry = 1'b0;
    dut_reset_c = 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        // Processor is held in reset while the sequencer is parked.
        dut_reset_c = 1'b1;
        if (start) begin
          state_d     = S_RST_SEQ;
          ecnt_d      = '0;
          epoch_d     = 2'd0;
          epoch_entry = 1'b1;
        end
      end

      S_RST_SEQ: begin
        // Reset pattern over ecnt 0..9: high 0-5, low 6-8, high again at 9.
        // The short release lets the processor step a few cycles, and the
        // final re-assert gives every epoch an identical starting point.
        dut_reset_c = (ecnt_q < ECNT_REL_LO) || (ecnt_q == ECNT_RST_END);
        ecnt_d      = ecnt_q + ECNT_ONE;
        if (ecnt_q == ECNT_RST_END) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        dut_reset_c = 1'b0;
        if (ecnt_q == ECNT_LAST) begin
          if (epoch_q == EPOCH_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_RST_SEQ;
            ecnt_d      = '0;
            epoch_d     = epoch_q + 2'd1;
            epoch_entry = 1'b1;
          end
        end else begin
          ecnt_d = ecnt_q + ECNT_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Seed, stimulus counter, signature accumulator and capture
  // ---------------------------------------------------------------------------
  always_comb begin
    // The seed is sampled only when an epoch begins, so host-side seed edits
    // during an epoch cannot corrupt that epoch's signature.
    seed_d = seed_q;
    if (epoch_entry) begin
      seed_d = (int'(epoch_d) >= ALT_EPOCH) ? seed_b : seed_a;
    end

    scr    = seed_q ^ obs_data;
    add    = acc_q[7:0] + scr;   // carry intentionally dropped
    stim_d = stim_q;
    acc_d  = acc_q;

    if (dut_reset_c) begin
      stim_d = 8'h00;
      acc_d  = 16'h0000;
    end else if (stim_q != 8'hFF) begin
      // The stimulus counter saturates at FF; once it does, the accumulator
      // freezes too, so the captured signature is independent of how long
      // the epoch runs after saturation.
      stim_d = stim_q + 8'd1;
      acc_d  = {acc_q[14:8], add, acc_q[15]};
    end

    // Capture takes the accumulator as it stands during cycle CAPTURE_AT; the
    // registered sig_valid then lines up with the new sig_data.
    capture     = (state_q == S_RUN) && (ecnt_q == ECNT_CAP);
    sig_valid_d = capture;
    sig_data_d  = sig_data_q;
    sig_epoch_d = sig_epoch_q;
    if (capture) begin
      sig_data_d  = acc_q;
      sig_epoch_d = epoch_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ecnt_q      <= '0;
      epoch_q     <= 2'd0;
      seed_q      <= seed_a;
      stim_q      <= 8'h00;
      acc_q       <= 16'h0000;
      sig_data_q  <= 16'h0000;
      sig_epoch_q <= 2'd0;
      sig_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ecnt_q      <= ecnt_d;
      epoch_q     <= epoch_d;
      seed_q      <= seed_d;
      stim_q      <= stim_d;
      acc_q       <= acc_d;
      sig_data_q  <= sig_data_d;
      sig_epoch_q <= sig_epoch_d;
      sig_valid_q <= sig_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // dut_reset is decoded from registered state/counter only, so it changes
  // exactly once per clock right after the edge.
  assign dut_reset = dut_reset_c;
  assign stimulus  = stim_q;
  assign seed      = seed_q;
  assign sig_data  = sig_data_q;
  assign sig_epoch = sig_epoch_q;
  assign sig_valid = sig_valid_q;
  assign busy      = (state_q == S_RST_SEQ) || (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

  // ---------------------------------------------------------------------------
  // Sanity checks
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      // A capture on the final epoch cycle would collide with the epoch
      // transition, so the capture point must leave at least one cycle spare.
      assert (CAPTURE_AT + 2 <= EPOCH_LEN)
        else $error("CAPTURE_AT must be at most EPOCH_LEN-2");
      assert (int'(epoch_q) <= NUM_EPOCHS - 1)
        else $error("epoch index exceeded NUM_EPOCHS-1");
    end
  end

endmodule

// File: tb/tb_signature_test_sequencer.sv
// -----------------------------------------------------------------------------
// tb_signature_test_sequencer
//
// Directed bench for signature_test_sequencer. A per-cycle table covers the
// reset pattern and stimulus counter of the first epochs; run-level sequences
// cover signature values, epoch seeds, saturation, abort and restart.
// A second instance with EPOCH_LEN=300 / CAPTURE_AT=290 runs in parallel.
// -----------------------------------------------------------------------------
module tb_signature_test_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  seed_a = 8'h00;
  logic [7:0]  seed_b = 8'h00;
  logic [7:0]  obs_data = 8'h00;

  logic        dut_reset, sig_valid, busy, done;
  logic [7:0]  stimulus, seed;
  logic [15:0] sig_data;
  logic [1:0]  sig_epoch;

  logic        s_dut_reset, s_sig_valid, s_busy, s_done;
  logic [7:0]  s_stimulus, s_seed;
  logic [15:0] s_sig_data;
  logic [1:0]  s_sig_epoch;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  signature_test_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .seed_a(seed_a), .seed_b(seed_b), .obs_data(obs_data),
    .dut_reset(dut_reset), .stimulus(stimulus), .seed(seed),
    .sig_data(sig_data), .sig_epoch(sig_epoch), .sig_valid(sig_valid),
    .busy(busy), .done(done)
  );

  signature_test_sequencer #(.EPOCH_LEN(300), .CAPTURE_AT(290), .NUM_EPOCHS(3), .ALT_EPOCH(2)) dut_s (
    .clk(clk), .reset(reset), .start(start),
    .seed_a(seed_a), .seed_b(seed_b), .obs_data(obs_data),
    .dut_reset(s_dut_reset), .stimulus(s_stimulus), .seed(s_seed),
    .sig_data(s_sig_data), .sig_epoch(s_sig_epoch), .sig_valid(s_sig_valid),
    .busy(s_busy), .done(s_done)
  );

  typedef struct {
    int         t;          // cycle offset from the start of the run
    logic       exp_rst;
    logic [7:0] exp_stim;
    logic       exp_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference signature after n accumulator updates with constant seed/obs.
  function automatic logic [15:0] model_sig(input logic [7:0] sd, input logic [7:0] ob, input int n);
    logic [15:0] a;
    logic [7:0]  s;
    a = 16'h0000;
    for (int k = 0; k < n; k++) begin
      s = a[7:0] + (sd ^ ob);
      a = {a[14:8], s, a[15]};
    end
    return a;
  endfunction

  // One run from a start pulse. Cycle t=0 is epoch 0, ecnt 0.
  task automatic do_run(input int run_id, input logic [7:0] sa, input logic [7:0] sb,
                        input logic [7:0] ob, input int n_cycles, input int abort_t,
                        input int exp_pulses);
    logic [15:0] m_a, m_b;
    int n_sig;
    int n_sig_s;
    int ti;
    n_sig   = 0;
    n_sig_s = 0;
    ti      = 0;
    // Counter saturates after 255 updates, well before either capture point.
    m_a = model_sig(sa, ob, 255);
    m_b = model_sig(sb, ob, 255);
    seed_a   = sa;
    seed_b   = sb;
    obs_data = ob;
    start    = 1'b1;
    step();
    start    = 1'b0;
    for (int t = 0; t <= n_cycles; t++) begin
      if (t > 0) step();

      if (sig_valid) begin
        check("sig_time", 32'(t), 32'(311 + 320 * n_sig));
        check("sig_epoch", 32'(sig_epoch), 32'(n_sig));
        check("sig_data", 32'(sig_data), 32'((n_sig >= 2) ? m_b : m_a));
        n_sig++;
      end

      if (t == 959) begin
        check("done_early", 32'(done), 32'h0);
        check("busy_last", 32'(busy), 32'h1);
      end
      if (t == 960) begin
        check("done_set", 32'(done), 32'h1);
        check("busy_clr", 32'(busy), 32'h0);
        check("done_rst", 32'(dut_reset), 32'h1);
      end

      if (run_id == 0) begin
        if (ti < tbl.size() && tbl[ti].t == t) begin
          $display("vec t=%0d rst=%0b stim=%02h busy=%0b", t, dut_reset, stimulus, busy);
          check("tbl_rst", 32'(dut_reset), 32'(tbl[ti].exp_rst));
          check("tbl_stim", 32'(stimulus), 32'(tbl[ti].exp_stim));
          check("tbl_busy", 32'(busy), 32'(tbl[ti].exp_busy));
          ti++;
        end
        // Mid-epoch seed edits must not reach the latched seed.
        if (t == 20)  seed_a = 8'h11;
        if (t == 100) seed_a = sa;
        if (t == 50 || t == 639) check("seed_a_hold", 32'(seed), 32'(sa));
        if (t == 640) check("seed_b_epoch2", 32'(seed), 32'(sb));
        // start while busy is ignored
        if (t == 400) start = 1'b1;
        if (t == 401) start = 1'b0;

        if (s_sig_valid) begin
          check("s_sig_time", 32'(t), 32'(291 + 300 * n_sig_s));
          check("s_sig_epoch", 32'(s_sig_epoch), 32'(n_sig_s));
          check("s_sig_data", 32'(s_sig_data), 32'((n_sig_s >= 2) ? m_b : m_a));
          n_sig_s++;
        end
        if (t == 264) check("s_stim_fe", 32'(s_stimulus), 32'hFE);
        if (t == 265) check("s_stim_ff", 32'(s_stimulus), 32'hFF);
        if (t == 299) check("s_stim_sat", 32'(s_stimulus), 32'hFF);
        if (t == 899) check("s_done_early", 32'(s_done), 32'h0);
        if (t == 900) check("s_done_set", 32'(s_done), 32'h1);
      end

      if (run_id == 1) begin
        if (t == 11) check("acc_1st", 32'(dut.acc_q), 32'h0002);
        if (t == 12) check("acc_2nd", 32'(dut.acc_q), 32'h0006);
      end

      if (abort_t >= 0 && t == abort_t) reset = 1'b1;
      if (abort_t >= 0 && t == abort_t + 1) begin
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_rst", 32'(dut_reset), 32'h1);
        check("abort_stim", 32'(stimulus), 32'h0);
        check("abort_sig", 32'(sig_data), 32'h0);
      end
    end
    $display("run %0d pulses=%0d expected=%0d", run_id, n_sig, exp_pulses);
    check("sig_count", 32'(n_sig), 32'(exp_pulses));
    if (run_id == 0) check("s_sig_count", 32'(n_sig_s), 32'h3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Cycle table for epoch 0/1 entry of run 0 (seed_a=AA, obs=0).
    tbl.push_back('{0,   1'b1, 8'h00, 1'b1});
    tbl.push_back('{3,   1'b1, 8'h00, 1'b1});
    tbl.push_back('{5,   1'b1, 8'h00, 1'b1});
    tbl.push_back('{6,   1'b0, 8'h00, 1'b1});
    tbl.push_back('{7,   1'b0, 8'h01, 1'b1});
    tbl.push_back('{8,   1'b0, 8'h02, 1'b1});
    tbl.push_back('{9,   1'b1, 8'h03, 1'b1});
    tbl.push_back('{10,  1'b0, 8'h00, 1'b1});
    tbl.push_back('{11,  1'b0, 8'h01, 1'b1});
    tbl.push_back('{12,  1'b0, 8'h02, 1'b1});
    tbl.push_back('{20,  1'b0, 8'h0A, 1'b1});
    tbl.push_back('{264, 1'b0, 8'hFE, 1'b1});
    tbl.push_back('{265, 1'b0, 8'hFF, 1'b1});
    tbl.push_back('{319, 1'b0, 8'hFF, 1'b1});
    tbl.push_back('{320, 1'b1, 8'hFF, 1'b1});
    tbl.push_back('{321, 1'b1, 8'h00, 1'b1});
    tbl.push_back('{329, 1'b1, 8'h03, 1'b1});
    tbl.push_back('{330, 1'b0, 8'h00, 1'b1});

    // Reset state
    seed_a = 8'hAA;
    reset  = 1'b1;
    repeat (3) step();
    $display("reset rst=%0b stim=%02h seed=%02h busy=%0b done=%0b", dut_reset, stimulus, seed, busy, done);
    check("rst_dut_reset", 32'(dut_reset), 32'h1);
    check("rst_stimulus", 32'(stimulus), 32'h0);
    check("rst_seed", 32'(seed), 32'hAA);
    check("rst_sig_data", 32'(sig_data), 32'h0);
    check("rst_sig_epoch", 32'(sig_epoch), 32'h0);
    check("rst_sig_valid", 32'(sig_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    reset = 1'b0;
    step();

    // Full run, seeds AA/5C
    do_run(0, 8'hAA, 8'h5C, 8'h00, 965, -1, 3);
    check("done_hold", 32'(done), 32'h1);

    // Restart from DONE, seed 01: accumulator steps 0000->0002->0006
    do_run(1, 8'h01, 8'h01, 8'h00, 965, -1, 3);

    // Restart from DONE, seed 00: zero signature; reset at epoch 1 ecnt 200
    do_run(2, 8'h00, 8'h00, 8'h00, 900, 520, 1);

    // start and reset together: reset wins
    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    step();
    $display("start+reset busy=%0b", busy);
    check("start_reset_busy", 32'(busy), 32'h0);

    // Restart after abort begins again at epoch 0, nonzero obs
    do_run(3, 8'h01, 8'h01, 8'h33, 330, -1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
